// File: rtl/zip_pkg.sv
// Shared constants and symbol layout for the 4:1 symbol packer and unpacker.
// Symbol 0 occupies the most significant byte of a packed word.
package zip_pkg;

    localparam int unsigned SYM_W       = 8;
    localparam int unsigned NIB_W       = 4;
    localparam int unsigned N_SYM       = 4;
    localparam int unsigned SAMP_HALF_W = 16;
    localparam int unsigned WORD_W      = SYM_W * N_SYM;
    localparam int unsigned SAMP_W      = 2 * SAMP_HALF_W;
    localparam int unsigned IDX_W       = 2;

    // One packed symbol: I in the upper nibble, Q in the lower.
    typedef struct packed {
        logic [NIB_W-1:0] i;
        logic [NIB_W-1:0] q;
    } sym_t;

    function automatic logic [SYM_W-1:0] sym_sel(input logic [WORD_W-1:0] word,
                                                 input logic [IDX_W-1:0]  idx);
        return word[(N_SYM - 1 - 32'(idx)) * SYM_W +: SYM_W];
    endfunction

endpackage

// File: rtl/zip_sym_expand.sv
// Expands one 8-bit I/Q symbol into a 32-bit sample, {I16, Q16}.
// ALIGN=1 MSB-justifies each nibble; ALIGN=0 sign-extends it.
module zip_sym_expand
    import zip_pkg::*;
#(
    parameter int unsigned ALIGN = 1
) (
    input  logic [SYM_W-1:0]  sym_i,
    output logic [SAMP_W-1:0] samp_o
);

    sym_t sym;

    assign sym = sym_t'(sym_i);

    function automatic logic [SAMP_HALF_W-1:0] widen(input logic [NIB_W-1:0] nib);
        if (ALIGN != 0) begin
            return {nib, {(SAMP_HALF_W - NIB_W){1'b0}}};
        end
        return {{(SAMP_HALF_W - NIB_W){nib[NIB_W-1]}}, nib};
    endfunction

    assign samp_o = {widen(sym.i), widen(sym.q)};

endmodule

// File: rtl/keep_one_in_n_unzip.sv
// Unpacks one 32-bit word of four I/Q symbols into four 32-bit AXI-Stream samples.
// A word accepted on the final output beat of the previous word refills without a bubble.
module keep_one_in_n_unzip
    import zip_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned ALIGN = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] i_tdata,
    input  logic             i_tlast,
    input  logic             i_tvalid,
    output logic             i_tready,
    output logic [WIDTH-1:0] o_tdata,
    output logic             o_tlast,
    output logic             o_tvalid,
    input  logic             o_tready
);

    logic [WIDTH-1:0] hold_data_q, hold_data_d;
    logic             hold_last_q, hold_last_d;
    logic             hold_vld_q, hold_vld_d;
    logic [IDX_W-1:0] idx_q, idx_d;

    logic last_sym;
    logic in_acc;
    logic out_acc;

    assign last_sym = (idx_q == IDX_W'(N_SYM - 1));
    assign i_tready = ~reset & (~hold_vld_q | (last_sym & o_tready));
    assign in_acc   = i_tvalid & i_tready;
    assign out_acc  = hold_vld_q & o_tready;

    always_comb begin
        hold_data_d = hold_data_q;
        hold_last_d = hold_last_q;
        hold_vld_d  = hold_vld_q;
        idx_d       = idx_q;
        if (out_acc) begin
            if (last_sym) begin
                hold_vld_d = 1'b0;
                idx_d      = '0;
            end else begin
                idx_d = idx_q + 1'b1;
            end
        end
        // A new word overrides exhaustion of the old one in the same cycle.
        if (in_acc) begin
            hold_data_d = i_tdata;
            hold_last_d = i_tlast;
            hold_vld_d  = 1'b1;
            idx_d       = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hold_data_q <= '0;
            hold_last_q <= 1'b0;
            hold_vld_q  <= 1'b0;
            idx_q       <= '0;
        end else begin
            hold_data_q <= hold_data_d;
            hold_last_q <= hold_last_d;
            hold_vld_q  <= hold_vld_d;
            idx_q       <= idx_d;
        end
    end

    assign o_tvalid = hold_vld_q;
    assign o_tlast  = hold_vld_q & hold_last_q & last_sym;

    zip_sym_expand #(
        .ALIGN(ALIGN)
    ) u_expand (
        .sym_i (sym_sel(hold_data_q, idx_q)),
        .samp_o(o_tdata)
    );

endmodule

// File: tb/tb_keep_one_in_n_unzip.sv
// Bench for keep_one_in_n_unzip: both ALIGN variants share stimulus and are checked
// against a queue-based model of the unpacked sample stream.
module tb_keep_one_in_n_unzip;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] i_tdata;
    logic        i_tlast;
    logic        i_tvalid;
    logic        o_tready;

    logic [31:0] o_tdata1, o_tdata0;
    logic        o_tlast1, o_tlast0;
    logic        o_tvalid1, o_tvalid0;
    logic        i_tready1, i_tready0;

    always #5 clk = ~clk;

    keep_one_in_n_unzip #(.WIDTH(32), .ALIGN(1)) dut1 (
        .clk(clk), .reset(reset), .i_tdata(i_tdata), .i_tlast(i_tlast),
        .i_tvalid(i_tvalid), .i_tready(i_tready1), .o_tdata(o_tdata1),
        .o_tlast(o_tlast1), .o_tvalid(o_tvalid1), .o_tready(o_tready)
    );

    keep_one_in_n_unzip #(.WIDTH(32), .ALIGN(0)) dut0 (
        .clk(clk), .reset(reset), .i_tdata(i_tdata), .i_tlast(i_tlast),
        .i_tvalid(i_tvalid), .i_tready(i_tready0), .o_tdata(o_tdata0),
        .o_tlast(o_tlast0), .o_tvalid(o_tvalid0), .o_tready(o_tready)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Pending expected samples, {tlast, tdata}, oldest first.
    logic [32:0] q1[$];
    logic [32:0] q0[$];

    bit          after_rst = 1'b0;
    bit          dir_on    = 1'b0;
    int          dir_k     = 0;
    logic [31:0] dir1[4];
    logic [31:0] dir0[4];

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [15:0] widen(input logic [3:0] nib, input bit msb);
        int v;
        if (msb) return 16'(int'(nib) * 4096);
        v = (nib >= 4'd8) ? int'(nib) - 16 : int'(nib);
        return 16'(v);
    endfunction

    task automatic push_word(input logic [31:0] word, input logic last);
        logic [7:0] sym;
        for (int s = 0; s < 4; s++) begin
            sym = 8'(word >> (8 * (3 - s)));
            q1.push_back({last && (s == 3), widen(sym[7:4], 1'b1), widen(sym[3:0], 1'b1)});
            q0.push_back({last && (s == 3), widen(sym[7:4], 1'b0), widen(sym[3:0], 1'b0)});
        end
    endtask

    // One clock cycle: drive at negedge, check just after, model transfers at posedge.
    task automatic step(input logic rst, input logic vld, input logic [31:0] data,
                        input logic last, input logic rdy, output bit took);
        logic        exp_rdy;
        logic [32:0] h1, h0;
        @(negedge clk);
        reset    = rst;
        i_tvalid = vld;
        i_tdata  = data;
        i_tlast  = last;
        o_tready = rdy;
        #1;
        took = 1'b0;
        if (rst) begin
            check_eq("i_tready_in_reset_a1", 32'(i_tready1), 32'd0);
            check_eq("i_tready_in_reset_a0", 32'(i_tready0), 32'd0);
            @(posedge clk);
            q1.delete();
            q0.delete();
            after_rst = 1'b1;
            return;
        end
        exp_rdy = (q1.size() == 0) || (q1.size() == 1 && rdy);
        check_eq("i_tready_a1", 32'(i_tready1), 32'(exp_rdy));
        check_eq("i_tready_a0", 32'(i_tready0), 32'(exp_rdy));
        check_eq("o_tvalid_a1", 32'(o_tvalid1), 32'(q1.size() != 0));
        check_eq("o_tvalid_a0", 32'(o_tvalid0), 32'(q0.size() != 0));
        if (after_rst) begin
            check_eq("rst_tdata_a1", o_tdata1, 32'd0);
            check_eq("rst_tdata_a0", o_tdata0, 32'd0);
            after_rst = 1'b0;
        end
        if (q1.size() != 0) begin
            h1 = q1[0];
            h0 = q0[0];
            check_eq("o_tdata_a1", o_tdata1, h1[31:0]);
            check_eq("o_tdata_a0", o_tdata0, h0[31:0]);
            check_eq("o_tlast_a1", 32'(o_tlast1), 32'(h1[32]));
            check_eq("o_tlast_a0", 32'(o_tlast0), 32'(h0[32]));
            if (rdy) begin
                if (dir_on && dir_k < 4) begin
                    check_eq("directed_a1", o_tdata1, dir1[dir_k]);
                    check_eq("directed_a0", o_tdata0, dir0[dir_k]);
                    dir_k++;
                end
                void'(q1.pop_front());
                void'(q0.pop_front());
            end
        end else begin
            check_eq("o_tlast_idle_a1", 32'(o_tlast1), 32'd0);
            check_eq("o_tlast_idle_a0", 32'(o_tlast0), 32'd0);
        end
        if (vld && exp_rdy) begin
            push_word(data, last);
            took = 1'b1;
        end
        @(posedge clk);
    endtask

    initial begin
        bit          took;
        int          k;
        int          guard;
        logic [31:0] w[3];
        logic [31:0] word;
        logic        wlast;

        reset    = 1'b1;
        i_tvalid = 1'b0;
        i_tdata  = '0;
        i_tlast  = 1'b0;
        o_tready = 1'b0;

        // Reset held with a valid word offered: nothing may be captured.
        for (int c = 0; c < 3; c++) step(1'b1, 1'b1, 32'hDEADBEEF, 1'b1, 1'b1, took);
        step(1'b0, 1'b0, '0, 1'b0, 1'b1, took);
        step(1'b0, 1'b0, '0, 1'b0, 1'b1, took);

        // Directed single word.
        dir1[0] = 32'hA0001000; dir1[1] = 32'hB000D000;
        dir1[2] = 32'hE000F000; dir1[3] = 32'h3000E000;
        dir0[0] = 32'hFFFA0001; dir0[1] = 32'hFFFBFFFD;
        dir0[2] = 32'hFFFEFFFF; dir0[3] = 32'h0003FFFE;
        dir_on = 1'b1;
        dir_k  = 0;
        step(1'b0, 1'b1, 32'hA1BDEF3E, 1'b0, 1'b1, took);
        check_eq("directed_accept", 32'(took), 32'd1);
        for (int c = 0; c < 4; c++) step(1'b0, 1'b0, '0, 1'b0, 1'b1, took);
        check_eq("directed_count", 32'(dir_k), 32'd4);
        dir_on = 1'b0;

        // Three back-to-back words, last one flagged.
        w[0] = 32'h0123_4567; w[1] = 32'h89AB_CDEF; w[2] = 32'hF0E1_D2C3;
        k     = 0;
        guard = 0;
        while (k < 3 && guard < 20) begin
            step(1'b0, 1'b1, w[k], k == 2, 1'b1, took);
            if (took) k++;
            guard++;
        end
        check_eq("continuous_words_accepted", 32'(k), 32'd3);
        check_eq("continuous_no_bubble_cycles", 32'(guard), 32'd9);
        for (int c = 0; c < 5; c++) step(1'b0, 1'b0, '0, 1'b0, 1'b1, took);

        // Reset after the second output of a word, then a fresh word.
        step(1'b0, 1'b1, 32'hCAFEF00D, 1'b1, 1'b1, took);
        step(1'b0, 1'b0, '0, 1'b0, 1'b1, took);
        step(1'b0, 1'b0, '0, 1'b0, 1'b1, took);
        step(1'b1, 1'b0, '0, 1'b0, 1'b1, took);
        dir1[0] = 32'h10002000; dir1[1] = 32'h30004000;
        dir1[2] = 32'h50006000; dir1[3] = 32'h70008000;
        dir0[0] = 32'h00010002; dir0[1] = 32'h00030004;
        dir0[2] = 32'h00050006; dir0[3] = 32'h0007FFF8;
        dir_on = 1'b1;
        dir_k  = 0;
        step(1'b0, 1'b1, 32'h12345678, 1'b0, 1'b1, took);
        for (int c = 0; c < 5; c++) step(1'b0, 1'b0, '0, 1'b0, 1'b1, took);
        check_eq("post_reset_count", 32'(dir_k), 32'd4);
        dir_on = 1'b0;

        // Random words, random valid and 50% backpressure.
        k     = 0;
        guard = 0;
        word  = $urandom;
        wlast = 1'(($urandom % 4) == 0);
        while (k < 1000 && guard < 40000) begin
            step(1'b0, 1'(($urandom % 4) != 0), word, wlast, 1'($urandom % 2), took);
            if (took) begin
                k++;
                word  = $urandom;
                wlast = 1'(($urandom % 4) == 0);
            end
            guard++;
        end
        check_eq("random_words_accepted", 32'(k), 32'd1000);
        guard = 0;
        while (q1.size() != 0 && guard < 50) begin
            step(1'b0, 1'b0, '0, 1'b0, 1'b1, took);
            guard++;
        end
        check_eq("drain_empty", 32'(q1.size()), 32'd0);
        step(1'b0, 1'b0, '0, 1'b0, 1'b1, took);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
